// File: rtl/prime_sieve_table_pkg.sv
// Shared types, defaults and width helpers for the prime sieve table block.
package prime_pkg;

  localparam int DEF_MAX_N      = 1024;
  localparam int DEF_MAX_PRIMES = 172;
  localparam int DEF_TAG_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SIEVE   = 3'd2,
    ST_COMPACT = 3'd3,
    ST_READY   = 3'd4
  } state_e;

  function automatic int val_width(input int max_n);
    return (max_n > 2) ? $clog2(max_n) : 1;
  endfunction

  function automatic int tag_width(input int max_primes);
    return $clog2(max_primes + 1);
  endfunction

endpackage

// File: rtl/prime_sieve_table_if.sv
// Control, cursor and lookup signals of the prime sieve table, seen from the
// requester (master) and from the sieve engine (slave).
interface prime_sieve_table_if
  import prime_pkg::*;
#(
  parameter int VAL_W = val_width(DEF_MAX_N),
  parameter int TAG_W = DEF_TAG_W
);

  logic             start;
  logic [VAL_W-1:0] limit;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [TAG_W-1:0] prime_count;
  logic             step_fwd;
  logic             step_bwd;
  logic [TAG_W-1:0] cur_idx;
  logic [TAG_W-1:0] nxt_idx;
  logic [VAL_W-1:0] cur_prime;
  logic [VAL_W-1:0] nxt_prime;
  logic             rd_en;
  logic [TAG_W-1:0] rd_idx;
  logic             rd_valid;
  logic             rd_hit;
  logic [VAL_W-1:0] rd_prime;

  modport master (
    output start, limit, step_fwd, step_bwd, rd_en, rd_idx,
    input  busy, done, overflow, prime_count, cur_idx, nxt_idx,
           cur_prime, nxt_prime, rd_valid, rd_hit, rd_prime
  );

  modport slave (
    input  start, limit, step_fwd, step_bwd, rd_en, rd_idx,
    output busy, done, overflow, prime_count, cur_idx, nxt_idx,
           cur_prime, nxt_prime, rd_valid, rd_hit, rd_prime
  );

endinterface

// File: rtl/prime_sieve_table_cursor.sv
// Wrapping 1-based display cursor bounded by the prime count; also exposes the
// next-state indices so the owner can register table reads in the same cycle.
module prime_cursor
  import prime_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             step_fwd_i,
  input  logic             step_bwd_i,
  input  logic [TAG_W-1:0] count_i,
  output logic [TAG_W-1:0] cur_idx_o,
  output logic [TAG_W-1:0] nxt_idx_o,
  output logic [TAG_W-1:0] cur_idx_d_o,
  output logic [TAG_W-1:0] nxt_idx_d_o
);

  localparam logic [TAG_W-1:0] ONE = TAG_W'(1);

  logic [TAG_W-1:0] cur_q, cur_d;
  logic [TAG_W-1:0] nxt_q, nxt_d;

  // Opposing simultaneous steps cancel; an empty table pins both indices at 0.
  always_comb begin
    cur_d = cur_q;
    if (clear_i) begin
      cur_d = '0;
    end else if (load_i) begin
      cur_d = (count_i == '0) ? '0 : ONE;
    end else if (en_i && (count_i != '0) && (step_fwd_i ^ step_bwd_i)) begin
      if (step_fwd_i) begin
        cur_d = (cur_q == count_i) ? ONE : cur_q + ONE;
      end else begin
        cur_d = (cur_q <= ONE) ? count_i : cur_q - ONE;
      end
    end else begin
      cur_d = cur_q;
    end

    nxt_d = '0;
    if ((count_i == '0) || (cur_d == '0)) begin
      nxt_d = '0;
    end else if (cur_d == count_i) begin
      nxt_d = ONE;
    end else begin
      nxt_d = cur_d + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
      nxt_q <= '0;
    end else begin
      cur_q <= cur_d;
      nxt_q <= nxt_d;
    end
  end

  assign cur_idx_o   = cur_q;
  assign nxt_idx_o   = nxt_q;
  assign cur_idx_d_o = cur_d;
  assign nxt_idx_d_o = nxt_d;

endmodule

// File: rtl/prime_sieve_table.sv
// Restartable Sieve of Eratosthenes with a compacted, overflow-aware 1-based
// prime table served through a display cursor and a registered lookup port.
module prime_sieve_table
  import prime_pkg::*;
#(
  parameter int MAX_N      = DEF_MAX_N,
  parameter int VAL_W      = val_width(MAX_N),
  parameter int MAX_PRIMES = DEF_MAX_PRIMES,
  parameter int TAG_W      = DEF_TAG_W
) (
  input logic                clk,
  input logic                reset,
  prime_sieve_table_if.slave bus
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_CLEAR   = ST_CLEAR;
  localparam logic [2:0] S_SIEVE   = ST_SIEVE;
  localparam logic [2:0] S_COMPACT = ST_COMPACT;
  localparam logic [2:0] S_READY   = ST_READY;

  localparam int               TBL_DEPTH = 1 << TAG_W;
  localparam int               SQ_W      = 2 * (VAL_W + 1);
  localparam logic [VAL_W:0]   MAX_N_W   = (VAL_W + 1)'(MAX_N);
  localparam logic [TAG_W-1:0] MAX_P_W   = TAG_W'(MAX_PRIMES);
  localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1);
  localparam logic [VAL_W:0]   W_ONE     = (VAL_W + 1)'(1);

  logic [2:0]       state_q, state_d;
  logic [VAL_W:0]   lim_q, lim_d, lim_clamp_s;
  logic [VAL_W:0]   i_q, i_d, i_inc_s;
  logic [VAL_W:0]   j_q, j_d, j_sq_next_s;
  logic [VAL_W-1:0] k_q, k_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [SQ_W-1:0]  i_sq_s;
  logic             strike_s;
  logic             wr_en_s;
  logic [TAG_W-1:0] wr_addr_s;
  logic [VAL_W-1:0] wr_data_s;

  logic [MAX_N-1:0] bitmap_q;
  logic [VAL_W-1:0] table_q [TBL_DEPTH];

  logic             busy_q, done_q;
  logic [VAL_W-1:0] cur_prime_q, cur_prime_d, nxt_prime_q, nxt_prime_d;
  logic             rd_valid_q, rd_hit_q, rd_hit_d;
  logic [VAL_W-1:0] rd_prime_q, rd_prime_d;
  logic [TAG_W-1:0] cur_idx_s, nxt_idx_s, cur_idx_d_s, nxt_idx_d_s;

  // j is one bit wider than a value so j+i and (i+1)^2 never wrap below L.
  assign lim_clamp_s = ({1'b0, bus.limit} >= MAX_N_W) ? MAX_N_W : {1'b0, bus.limit};
  assign i_inc_s     = i_q + W_ONE;
  assign j_sq_next_s = i_inc_s * i_inc_s;
  assign i_sq_s      = SQ_W'(i_q) * SQ_W'(i_q);
  assign wr_addr_s   = count_q + TAG_ONE;
  assign wr_data_s   = k_q;

  always_comb begin
    state_d  = state_q;
    lim_d    = lim_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    strike_s = 1'b0;
    wr_en_s  = 1'b0;
    case (state_q)
      S_IDLE, S_READY: begin
        if (bus.start) begin
          lim_d   = lim_clamp_s;
          state_d = S_CLEAR;
        end else begin
          state_d = state_q;
        end
      end
      S_CLEAR: begin
        count_d = '0;
        ovf_d   = 1'b0;
        i_d     = (VAL_W + 1)'(2);
        j_d     = (VAL_W + 1)'(4);
        state_d = S_SIEVE;
      end
      S_SIEVE: begin
        if (i_sq_s >= SQ_W'(lim_q)) begin
          k_d     = VAL_W'(2);
          state_d = (lim_q < (VAL_W + 1)'(3)) ? S_READY : S_COMPACT;
        end else if (!bitmap_q[i_q[VAL_W-1:0]]) begin
          i_d = i_inc_s;
          j_d = j_sq_next_s;
        end else if (j_q < lim_q) begin
          strike_s = 1'b1;
          j_d      = j_q + i_q;
        end else begin
          i_d = i_inc_s;
          j_d = j_sq_next_s;
        end
      end
      S_COMPACT: begin
        if (bitmap_q[k_q]) begin
          if (count_q < MAX_P_W) begin
            wr_en_s = 1'b1;
            count_d = wr_addr_s;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          count_d = count_q;
        end
        if ({1'b0, k_q} == (lim_q - W_ONE)) begin
          state_d = S_READY;
        end else begin
          k_d = k_q + VAL_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lim_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_SIEVE) || (state_d == S_COMPACT);
      done_q  <= (state_d == S_READY);
    end
  end

  // Bitmap and table carry no reset: both are rebuilt by CLEAR/COMPACT before use.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      bitmap_q <= '1;
    end else if (strike_s) begin
      bitmap_q[j_q[VAL_W-1:0]] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      table_q[wr_addr_s] <= wr_data_s;
    end
  end

  prime_cursor #(.TAG_W(TAG_W)) u_cursor (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (state_q == S_CLEAR),
    .load_i      ((state_q != S_READY) && (state_d == S_READY)),
    .en_i        (state_q == S_READY),
    .step_fwd_i  (bus.step_fwd),
    .step_bwd_i  (bus.step_bwd),
    .count_i     (count_d),
    .cur_idx_o   (cur_idx_s),
    .nxt_idx_o   (nxt_idx_s),
    .cur_idx_d_o (cur_idx_d_s),
    .nxt_idx_d_o (nxt_idx_d_s)
  );

  // The last compact write can land on the entry the cursor loads, so forward it.
  always_comb begin
    cur_prime_d = '0;
    nxt_prime_d = '0;
    if (cur_idx_d_s == '0) begin
      cur_prime_d = '0;
    end else if (wr_en_s && (wr_addr_s == cur_idx_d_s)) begin
      cur_prime_d = wr_data_s;
    end else begin
      cur_prime_d = table_q[cur_idx_d_s];
    end
    if (nxt_idx_d_s == '0) begin
      nxt_prime_d = '0;
    end else if (wr_en_s && (wr_addr_s == nxt_idx_d_s)) begin
      nxt_prime_d = wr_data_s;
    end else begin
      nxt_prime_d = table_q[nxt_idx_d_s];
    end
  end

  always_comb begin
    rd_hit_d   = bus.rd_en && done_q && (bus.rd_idx != '0) && (bus.rd_idx <= count_q);
    rd_prime_d = '0;
    if (rd_hit_d) begin
      rd_prime_d = table_q[bus.rd_idx];
    end else begin
      rd_prime_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_prime_q <= '0;
      nxt_prime_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_hit_q    <= 1'b0;
      rd_prime_q  <= '0;
    end else begin
      cur_prime_q <= cur_prime_d;
      nxt_prime_q <= nxt_prime_d;
      rd_valid_q  <= bus.rd_en;
      rd_hit_q    <= rd_hit_d;
      rd_prime_q  <= rd_prime_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.prime_count = count_q;
  assign bus.cur_idx     = cur_idx_s;
  assign bus.nxt_idx     = nxt_idx_s;
  assign bus.cur_prime   = cur_prime_q;
  assign bus.nxt_prime   = nxt_prime_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_hit      = rd_hit_q;
  assign bus.rd_prime    = rd_prime_q;

endmodule

// File: tb/tb_prime_sieve_table.sv
// Two instances (default depth and a 10-entry table) driven in lockstep and
// checked against a trial-division prime list.
module tb_prime_sieve_table;
  import prime_pkg::*;

  localparam int MP_A = 172;
  localparam int MP_B = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_p [0:1023];
  int   exp_n;
  int   cnt_a, cnt_b, ca, cb;

  prime_sieve_table_if #(.VAL_W(10), .TAG_W(8)) ifa ();
  prime_sieve_table_if #(.VAL_W(10), .TAG_W(8)) ifb ();

  prime_sieve_table dut_a (.clk(clk), .reset(reset), .bus(ifa));
  prime_sieve_table #(.MAX_PRIMES(MP_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifb.start    = ifa.start;
  assign ifb.limit    = ifa.limit;
  assign ifb.step_fwd = ifa.step_fwd;
  assign ifb.step_bwd = ifa.step_bwd;
  assign ifb.rd_en    = ifa.rd_en;
  assign ifb.rd_idx   = ifa.rd_idx;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_ref(input int lim);
    int l;
    l = (lim > 1024) ? 1024 : lim;
    exp_n = 0;
    for (int v = 2; v < l; v++) begin
      if (is_prime(v)) begin
        exp_n++;
        exp_p[exp_n] = v;
      end
    end
  endtask

  function automatic int pval(input int idx, input int cnt);
    return (idx >= 1 && idx <= cnt) ? exp_p[idx] : 0;
  endfunction

  function automatic int nxt_of(input int cur, input int cnt);
    if (cnt == 0) return 0;
    return (cur == cnt) ? 1 : cur + 1;
  endfunction

  function automatic int step_of(input int cur, input int cnt, input bit f, input bit b);
    if (cnt == 0 || f == b) return cur;
    if (f) return (cur == cnt) ? 1 : cur + 1;
    return (cur == 1) ? cnt : cur - 1;
  endfunction

  task automatic chk_cursor();
    chk("a_cur_idx",   ifa.cur_idx,   ca);
    chk("a_nxt_idx",   ifa.nxt_idx,   nxt_of(ca, cnt_a));
    chk("a_cur_prime", ifa.cur_prime, pval(ca, cnt_a));
    chk("a_nxt_prime", ifa.nxt_prime, pval(nxt_of(ca, cnt_a), cnt_a));
    chk("b_cur_idx",   ifb.cur_idx,   cb);
    chk("b_nxt_idx",   ifb.nxt_idx,   nxt_of(cb, cnt_b));
    chk("b_cur_prime", ifb.cur_prime, pval(cb, cnt_b));
    chk("b_nxt_prime", ifb.nxt_prime, pval(nxt_of(cb, cnt_b), cnt_b));
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", ifa.busy, 0);           chk("rst_done", ifa.done, 0);
    chk("rst_ovf", ifa.overflow, 0);        chk("rst_count", ifa.prime_count, 0);
    chk("rst_cur_idx", ifa.cur_idx, 0);     chk("rst_nxt_idx", ifa.nxt_idx, 0);
    chk("rst_cur_prime", ifa.cur_prime, 0); chk("rst_nxt_prime", ifa.nxt_prime, 0);
    chk("rst_rd_valid", ifa.rd_valid, 0);   chk("rst_rd_hit", ifa.rd_hit, 0);
    chk("rst_rd_prime", ifa.rd_prime, 0);   chk("rst_b_done", ifb.done, 0);
  endtask

  task automatic start_pulse(input int lim);
    ifa.limit = 10'(lim);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    build_ref(lim);
    chk("start_busy_a", ifa.busy, 1);
    chk("start_busy_b", ifb.busy, 1);
    chk("start_done_a", ifa.done, 0);
  endtask

  task automatic finish_run();
    int n = 0;
    while (!(ifa.done && ifb.done) && n < 20000) begin
      tick();
      n++;
    end
    chk("done_timeout", ifa.done && ifb.done, 1);
    cnt_a = (exp_n < MP_A) ? exp_n : MP_A;
    cnt_b = (exp_n < MP_B) ? exp_n : MP_B;
    ca = (cnt_a == 0) ? 0 : 1;
    cb = (cnt_b == 0) ? 0 : 1;
    chk("a_busy_end", ifa.busy, 0);
    chk("a_count", ifa.prime_count, cnt_a);
    chk("a_ovf", ifa.overflow, exp_n > MP_A);
    chk("b_count", ifb.prime_count, cnt_b);
    chk("b_ovf", ifb.overflow, exp_n > MP_B);
    chk_cursor();
  endtask

  // rd_en held high across calls gives back-to-back requests.
  task automatic lookup(input int idx, input bit rdy);
    ifa.rd_en  = 1'b1;
    ifa.rd_idx = 8'(idx);
    tick();
    chk("a_rd_valid", ifa.rd_valid, 1);
    chk("a_rd_hit",   ifa.rd_hit,   rdy && idx >= 1 && idx <= cnt_a);
    chk("a_rd_prime", ifa.rd_prime, rdy ? pval(idx, cnt_a) : 0);
    chk("b_rd_valid", ifb.rd_valid, 1);
    chk("b_rd_hit",   ifb.rd_hit,   rdy && idx >= 1 && idx <= cnt_b);
    chk("b_rd_prime", ifb.rd_prime, rdy ? pval(idx, cnt_b) : 0);
  endtask

  task automatic lookup_end();
    ifa.rd_en = 1'b0;
    tick();
    chk("rd_valid_drop", ifa.rd_valid, 0);
  endtask

  task automatic step(input bit f, input bit b);
    ifa.step_fwd = f;
    ifa.step_bwd = b;
    tick();
    ifa.step_fwd = 1'b0;
    ifa.step_bwd = 1'b0;
    ca = step_of(ca, cnt_a, f, b);
    cb = step_of(cb, cnt_b, f, b);
    chk_cursor();
  endtask

  initial begin
    int lim;
    ifa.start = 1'b0; ifa.limit = '0; ifa.step_fwd = 1'b0; ifa.step_bwd = 1'b0;
    ifa.rd_en = 1'b0; ifa.rd_idx = '0;
    cnt_a = 0; cnt_b = 0; ca = 0; cb = 0;
    tick(); tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    // Largest representable limit: all primes below 1023 (same set as below 1024).
    start_pulse(1023);
    finish_run();
    chk("full_count_172", ifa.prime_count, 172);
    chk("full_cur_prime_2", ifa.cur_prime, 2);
    chk("full_nxt_prime_3", ifa.nxt_prime, 3);
    for (int idx = 0; idx < 176; idx++) lookup(idx, 1'b1);
    lookup(255, 1'b1);
    lookup_end();
    lookup(172, 1'b1);
    chk("tbl172_1021", ifa.rd_prime, 1021);
    lookup_end();
    step(1'b0, 1'b1);
    chk("wrap_bwd_172", ifa.cur_idx, 172);
    step(1'b1, 1'b0);
    chk("wrap_fwd_1", ifa.cur_idx, 1);
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("both_hold_5", ifa.cur_idx, 5);
    for (int s = 0; s < 300; s++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Restart from READY, then a start during SIEVE must be ignored.
    start_pulse(30);
    tick(); tick(); tick();
    chk("in_sieve_busy", ifa.busy, 1);
    lookup(1, 1'b0);
    lookup_end();
    ifa.limit = 10'd100;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    finish_run();
    chk("lim30_count_10", ifa.prime_count, 10);
    lookup(10, 1'b1);
    chk("lim30_tbl10_29", ifa.rd_prime, 29);
    lookup_end();
    step(1'b0, 1'b1);
    chk("lim30_bwd_idx", ifa.cur_idx, 10);
    chk("lim30_bwd_prime", ifa.cur_prime, 29);

    // Limit 100 overflows the 10-entry instance.
    start_pulse(100);
    finish_run();
    chk("b_ovf_set", ifb.overflow, 1);
    lookup(10, 1'b1);
    lookup(11, 1'b1);
    chk("b_miss_11", ifb.rd_hit, 0);
    lookup_end();

    // Empty table.
    start_pulse(2);
    finish_run();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    lookup(1, 1'b1);
    lookup_end();

    for (int r = 0; r < 5; r++) begin
      lim = $urandom_range(0, 1023);
      start_pulse(lim);
      finish_run();
      for (int q = 0; q < 12; q++) lookup($urandom_range(0, 255), 1'b1);
      lookup_end();
      for (int s = 0; s < 20; s++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of SIEVE, then a full clean rerun.
    start_pulse(1023);
    for (int s = 0; s < 20; s++) tick();
    chk("mid_sieve_busy", ifa.busy, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    start_pulse(1023);
    finish_run();
    chk("rerun_count_172", ifa.prime_count, 172);
    chk("rerun_cur_prime_2", ifa.cur_prime, 2);
    chk("rerun_nxt_prime_3", ifa.nxt_prime, 3);
    lookup(172, 1'b1);
    chk("rerun_tbl172", ifa.rd_prime, 1021);
    lookup_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
